// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the iterative radix-2 FFT datapath.
//   CPLX_W / HALF_W : packed complex word width and per-component width
//   cplx_t          : {re, im} view of a complex word, both signed
//   state_t         : stage sequencer states
//   re()/im()/pack(): split and join packed complex words
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int CPLX_W = 36;
  localparam int HALF_W = 18;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Real part lives in the upper half of the packed word
  function automatic logic signed [HALF_W-1:0] re(input logic [CPLX_W-1:0] w);
    return w[CPLX_W-1:HALF_W];
  endfunction

  function automatic logic signed [HALF_W-1:0] im(input logic [CPLX_W-1:0] w);
    return w[HALF_W-1:0];
  endfunction

  function automatic logic [CPLX_W-1:0] pack(input logic signed [HALF_W-1:0] r,
                                              input logic signed [HALF_W-1:0] i);
    return {r, i};
  endfunction

endpackage

// File: rtl/butterfly_unit.sv
// ---------------------------------------------------------------------------
// butterfly_unit
// Combinational radix-2 DIT butterfly: p = a + w*b, n = a - w*b.
// Complex words are {re, im}, signed 18-bit each. The twiddle w is Q2.16
// (1.0 = 65536). The product is rounded half-up back to sample scale and the
// final sums saturate to the 18-bit range; there is no stage scaling.
//   a, b : butterfly input samples
//   w    : twiddle factor
//   p, n : sum and difference outputs
// ---------------------------------------------------------------------------
module butterfly_unit
  import fft_pkg::*;
(
  input  logic [CPLX_W-1:0] a,
  input  logic [CPLX_W-1:0] b,
  input  logic [CPLX_W-1:0] w,
  output logic [CPLX_W-1:0] p,
  output logic [CPLX_W-1:0] n
);

  localparam logic signed [36:0] RND   = 37'sd32768;
  localparam logic signed [36:0] MAX18 = 37'sd131071;
  localparam logic signed [36:0] MIN18 = -37'sd131072;

  function automatic logic signed [HALF_W-1:0] sat18(input logic signed [36:0] v);
    if (v > MAX18)      return HALF_W'(MAX18);
    else if (v < MIN18) return HALF_W'(MIN18);
    else                return v[HALF_W-1:0];
  endfunction

  logic signed [36:0] ar, ai, br, bi, wr, wi;
  logic signed [36:0] mr, mi, tr, ti;

  // Full-precision complex multiply, then drop the 16 fractional twiddle bits
  always_comb begin
    ar = 37'(re(a));
    ai = 37'(im(a));
    br = 37'(re(b));
    bi = 37'(im(b));
    wr = 37'(re(w));
    wi = 37'(im(w));
    mr = br * wr - bi * wi;
    mi = br * wi + bi * wr;
    tr = (mr + RND) >>> 16;
    ti = (mi + RND) >>> 16;
    p  = pack(sat18(ar + tr), sat18(ai + ti));
    n  = pack(sat18(ar - tr), sat18(ai - ti));
  end

endmodule

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
// Combinational address generator for an in-place radix-2 DIT FFT.
// Maps (stage s, butterfly k) to the two RAM addresses of the butterfly and
// the twiddle ROM index. Shared with the unload stage.
//   s  : stage number, 0..LOGN-1
//   k  : butterfly number within the stage, 0..N/2-1
//   a  : upper-leg address
//   b  : lower-leg address (a + 2^s)
//   tw : twiddle index into a table of W^k, k = 0..N/2-1
// ---------------------------------------------------------------------------
module fft_addr_gen #(
  parameter int LOGN = 4,
  parameter int SW   = (LOGN > 1) ? $clog2(LOGN) : 1
) (
  input  logic [SW-1:0]   s,
  input  logic [LOGN-2:0] k,
  output logic [LOGN-1:0] a,
  output logic [LOGN-1:0] b,
  output logic [LOGN-2:0] tw
);

  localparam logic [SW:0] TOP = (SW+1)'(LOGN-1);

  logic [LOGN-2:0] mask;
  logic [LOGN-2:0] low;
  logic [LOGN-1:0] hi;
  logic [SW:0]     s_ext;

  // Insert a zero at bit position s of k to form the upper leg; the lower
  // leg has that bit set. The twiddle stride doubles as s drops.
  always_comb begin
    s_ext = {1'b0, s};
    // At s = LOGN-1 the shifted one falls off the top of the LOGN-1 bit
    // field, so the subtraction wraps to all ones, which is the mask wanted.
    mask  = ((LOGN-1)'(1) << s) - (LOGN-1)'(1);
    low   = k & mask;
    hi    = (LOGN'(k) >> s) << (s_ext + (SW+1)'(1));
    a     = hi | {1'b0, low};
    b     = a + (LOGN'(1) << s);
    tw    = low << (TOP - s_ext);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
// Iterative radix-2 DIT FFT controller around an external combinational
// butterfly. Walks LOGN stages of N/2 butterflies over an in-place sample
// RAM (bit-reversed in, natural order out), one butterfly per cycle.
//   clk, reset              : clock, asynchronous active-high reset
//   start                   : begin a transform (accepted only when idle)
//   busy, done              : transform in progress / one-cycle completion
//   rd_addr_a/b, rd_data_a/b: RAM read ports, data one cycle after address
//   tw_idx, tw_data         : twiddle ROM port, data one cycle after index
//   bf_a, bf_b, bf_w        : butterfly inputs (RAM/ROM data passed through)
//   bf_p, bf_n              : butterfly results returned from the parent
//   wr_en, wr_addr_a/b, wr_data_a/b : dual RAM write-back
// ---------------------------------------------------------------------------
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N    = 16,
  parameter int LOGN = $clog2(N),
  parameter int DW   = CPLX_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  input  logic [DW-1:0]   rd_data_a,
  input  logic [DW-1:0]   rd_data_b,
  output logic [LOGN-2:0] tw_idx,
  input  logic [DW-1:0]   tw_data,
  output logic [DW-1:0]   bf_a,
  output logic [DW-1:0]   bf_b,
  output logic [DW-1:0]   bf_w,
  input  logic [DW-1:0]   bf_p,
  input  logic [DW-1:0]   bf_n,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic [DW-1:0]   wr_data_a,
  output logic [DW-1:0]   wr_data_b
);

  localparam int KW = LOGN - 1;
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

  state_t          state, state_next;
  logic [SW-1:0]   s_q, s_next;
  logic [KW-1:0]   k_q, k_next;
  logic            d_q, d_next;

  logic [LOGN-1:0] gen_a, gen_b;
  logic [KW-1:0]   gen_tw;

  logic            issue_valid;
  logic            v1;
  logic [LOGN-1:0] a1, b1;

  fft_addr_gen #(.LOGN(LOGN), .SW(SW)) u_addr_gen (
    .s  (s_q),
    .k  (k_q),
    .a  (gen_a),
    .b  (gen_b),
    .tw (gen_tw)
  );

  assign bf_a = rd_data_a;
  assign bf_b = rd_data_b;
  assign bf_w = tw_data;

  // State register with stage, butterfly and drain counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s_q   <= '0;
      k_q   <= '0;
      d_q   <= 1'b0;
    end else begin
      state <= state_next;
      s_q   <= s_next;
      k_q   <= k_next;
      d_q   <= d_next;
    end
  end

  // Stage walk. The done pulse is visible while already back in IDLE, so it
  // masks start there to keep a start coincident with done from launching.
  always_comb begin
    state_next = state;
    s_next     = s_q;
    k_next     = k_q;
    d_next     = d_q;
    case (state)
      IDLE: begin
        if (start && !done) begin
          state_next = RUN;
          s_next     = '0;
          k_next     = '0;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_next = DRAIN;
          d_next     = 1'b0;
        end else begin
          k_next = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (d_q) begin
          if (s_q == S_LAST) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
            s_next     = s_q + SW'(1);
            k_next     = '0;
          end
        end else begin
          d_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Three-slot pipeline: issue addresses, let RAM/ROM data feed the
  // butterfly, then present registered results with their addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      tw_idx      <= '0;
      issue_valid <= 1'b0;
      v1          <= 1'b0;
      a1          <= '0;
      b1          <= '0;
      wr_en       <= 1'b0;
      wr_addr_a   <= '0;
      wr_addr_b   <= '0;
      wr_data_a   <= '0;
      wr_data_b   <= '0;
    end else begin
      busy        <= (state == RUN) || (state == DRAIN);
      done        <= (state == DONE);
      issue_valid <= (state == RUN);
      if (state == RUN) begin
        rd_addr_a <= gen_a;
        rd_addr_b <= gen_b;
        tw_idx    <= gen_tw;
      end
      v1    <= issue_valid;
      a1    <= rd_addr_a;
      b1    <= rd_addr_b;
      wr_en <= v1;
      if (v1) begin
        wr_addr_a <= a1;
        wr_addr_b <= b1;
        wr_data_a <= bf_p;
        wr_data_b <= bf_n;
      end
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Bench for the FFT stage sequencer with sample RAM, twiddle ROM and
// butterfly. Results are compared with a direct DFT computed in reals;
// cycle timing and addresses are compared with a pair-enumeration model.
// ---------------------------------------------------------------------------
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int N     = 16;
  localparam int LOGN  = 4;
  localparam int P     = N/2 + 2;
  localparam int TOTAL = LOGN * P;
  localparam real PI   = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, wr_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOGN-2:0] tw_idx;
  logic [CPLX_W-1:0] rd_data_a, rd_data_b, tw_data;
  logic [CPLX_W-1:0] bf_a, bf_b, bf_w, bf_p, bf_n, wr_data_a, wr_data_b;

  logic [CPLX_W-1:0] mem [N];
  logic [CPLX_W-1:0] rom [N/2];
  logic              load_en;
  logic [LOGN-1:0]   load_addr;
  logic [CPLX_W-1:0] load_data;

  int xr [N];
  int xi [N];
  int assert_count = 0;
  int fail_count   = 0;
  int req_id = 0, seen_id = 0, mon_done_id = 0;
  int mon_c = 0, wr_count = 0;
  bit mon_active = 1'b0;
  int lit_a [4]  = '{0, 1, 4, 5};
  int lit_b [4]  = '{2, 3, 6, 7};
  int lit_tw [4] = '{0, 4, 0, 4};

  fft_stage_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .tw_idx(tw_idx), .tw_data(tw_data),
    .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_p(bf_p), .bf_n(bf_n),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
  );

  butterfly_unit u_bf (.a(bf_a), .b(bf_b), .w(bf_w), .p(bf_p), .n(bf_n));

  always #5 clk = ~clk;

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < LOGN; i++) if ((v >> i) & 1) r |= 1 << (LOGN-1-i);
    return r;
  endfunction

  // Twiddle table W^k = exp(-j*2*pi*k/N) in Q2.16
  initial begin
    for (int k = 0; k < N/2; k++)
      rom[k] = pack(18'(rnd(65536.0 * $cos(2.0*PI*k/N))),
                    18'(rnd(-65536.0 * $sin(2.0*PI*k/N))));
  end

  // Synchronous RAM: reads return the pre-write contents of the same edge
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (wr_en) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
    rd_data_a <= mem[rd_addr_a];
    rd_data_b <= mem[rd_addr_b];
    tw_data   <= rom[tw_idx];
  end

  task automatic checkOutput(input string name, input int actual,
                             input int expected, input int tol);
    int d = actual - expected;
    assert_count++;
    if (d > tol || -d > tol) begin
      fail_count++;
      $display("[TB] FAIL %s actual=%0d expected=%0d tol=%0d", name, actual, expected, tol);
    end
  endtask

  // k-th pair of stage s: indices with bit s clear, taken in ascending order
  function automatic int pairA(input int s, input int k);
    int cnt = 0;
    int res = 0;
    for (int i = 0; i < N; i++)
      if (((i >> s) & 1) == 0) begin
        if (cnt == k) res = i;
        cnt++;
      end
    return res;
  endfunction

  // Per-cycle timing/address monitor, cycle 0 is the one after the accepting edge
  always @(negedge clk) begin
    int rel, s, k, ea;
    if (req_id != seen_id) begin
      seen_id    = req_id;
      mon_c      = 0;
      wr_count   = 0;
      mon_active = 1'b1;
    end
    if (mon_active) begin
      checkOutput($sformatf("busy@%0d", mon_c), int'(busy), int'(mon_c >= 1 && mon_c <= TOTAL), 0);
      checkOutput($sformatf("done@%0d", mon_c), int'(done), int'(mon_c == TOTAL + 1), 0);
      rel = mon_c - 1; s = rel / P; k = rel % P;
      if (mon_c >= 1 && mon_c <= TOTAL && k < N/2) begin
        ea = pairA(s, k);
        checkOutput($sformatf("rd_addr_a@%0d", mon_c), int'(rd_addr_a), ea, 0);
        checkOutput($sformatf("rd_addr_b@%0d", mon_c), int'(rd_addr_b), ea + (1 << s), 0);
        checkOutput($sformatf("tw_idx@%0d", mon_c), int'(tw_idx), (ea % (1 << s)) * (N >> (s+1)), 0);
      end
      if (mon_c >= 1 + P && mon_c <= 4 + P) begin
        checkOutput("stage1_lit_a", int'(rd_addr_a), lit_a[mon_c-1-P], 0);
        checkOutput("stage1_lit_b", int'(rd_addr_b), lit_b[mon_c-1-P], 0);
        checkOutput("stage1_lit_tw", int'(tw_idx), lit_tw[mon_c-1-P], 0);
      end
      rel = mon_c - 3; s = rel / P; k = rel % P;
      if (mon_c >= 3 && mon_c <= TOTAL && k < N/2) begin
        ea = pairA(s, k);
        checkOutput($sformatf("wr_en@%0d", mon_c), int'(wr_en), 1, 0);
        checkOutput($sformatf("wr_addr_a@%0d", mon_c), int'(wr_addr_a), ea, 0);
        checkOutput($sformatf("wr_addr_b@%0d", mon_c), int'(wr_addr_b), ea + (1 << s), 0);
      end else begin
        checkOutput($sformatf("wr_en@%0d", mon_c), int'(wr_en), 0, 0);
      end
      if (wr_en) wr_count++;
      mon_c++;
      if (mon_c > TOTAL + 4) begin
        checkOutput("wr_en_cycles", wr_count, 32, 0);
        mon_active  = 1'b0;
        mon_done_id = seen_id;
      end
    end
  end

  // Loads one of the test vectors into RAM in bit-reversed order
  task automatic loadRam(input int kind);
    for (int n = 0; n < N; n++) begin
      case (kind)
        0: xr[n] = (n == 0) ? (1 << 10) : 0;
        1: xr[n] = 1 << 8;
        default: xr[n] = rnd(4096.0 * $cos(2.0*PI*n/N));
      endcase
      xi[n] = 0;
    end
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = LOGN'(bitrev(n));
      load_data = pack(18'(xr[n]), 18'(xi[n]));
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Runs one transform; optionally pulses start mid-run or alongside done
  task automatic applyStimulus(input int kind, input int glitch_at, input bit start_at_done);
    int cur, guard;
    loadRam(kind);
    start = 1'b1;
    @(posedge clk);
    req_id++;
    @(negedge clk);
    start = 1'b0;
    cur = 0;
    if (glitch_at > 0) begin
      repeat (glitch_at) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cur = glitch_at + 1;
    end
    if (start_at_done) begin
      repeat (TOTAL + 1 - cur) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (mon_done_id != req_id && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("run_timeout", int'(mon_done_id != req_id), 0, 0);
  endtask

  // Direct DFT of the loaded samples against the natural-order RAM contents
  task automatic checkResults(input string tag, input int tol);
    real sr, si, ang;
    for (int k = 0; k < N; k++) begin
      sr = 0.0; si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * PI * k * n / N;
        sr += xr[n] * $cos(ang) + xi[n] * $sin(ang);
        si += xi[n] * $cos(ang) - xr[n] * $sin(ang);
      end
      checkOutput($sformatf("%s_X%0d_re", tag, k), int'(re(mem[k])), rnd(sr), tol);
      checkOutput($sformatf("%s_X%0d_im", tag, k), int'(im(mem[k])), rnd(si), tol);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0, 0);
    checkOutput("reset_done", int'(done), 0, 0);
    checkOutput("reset_wr_en", int'(wr_en), 0, 0);
    checkOutput("reset_rd_addr_a", int'(rd_addr_a), 0, 0);
    checkOutput("reset_tw_idx", int'(tw_idx), 0, 0);
    checkOutput("reset_wr_data_a", int'(wr_data_a != 0), 0, 0);
    reset = 1'b0;

    $display("[TB] impulse");
    applyStimulus(0, 0, 1'b0);
    checkResults("impulse", 1);
    checkOutput("impulse_X0_lit", int'(re(mem[0])), 1024, 1);
    checkOutput("impulse_X9_lit", int'(re(mem[9])), 1024, 1);

    $display("[TB] dc, start held with done");
    applyStimulus(1, 0, 1'b1);
    checkResults("dc", 2);
    checkOutput("dc_X0_lit", int'(re(mem[0])), 4096, 2);
    checkOutput("dc_X8_lit", int'(re(mem[8])), 0, 2);

    $display("[TB] tone");
    applyStimulus(2, 0, 1'b0);
    checkResults("tone", 4);
    checkOutput("tone_X1_lit", int'(re(mem[1])), 32768, 4);
    checkOutput("tone_X15_lit", int'(re(mem[15])), 32768, 4);
    checkOutput("tone_X2_lit", int'(re(mem[2])), 0, 4);

    $display("[TB] tone, start pulsed mid-run");
    applyStimulus(2, 20, 1'b0);
    checkResults("tone_glitch", 4);

    $display("[TB] reset mid-run");
    loadRam(2);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", int'(busy), 0, 0);
    checkOutput("midreset_wr_en", int'(wr_en), 0, 0);
    checkOutput("midreset_done", int'(done), 0, 0);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 1'b0);
    checkResults("after_reset", 1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
